// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load/branch hazard detection and multi-cycle EX stall
// control for an in-order pipeline; StallCount tracks cumulative ID stall cycles.
module fwd_hazard_unit #(
  parameter int unsigned AW       = 5,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned MUL_LAT  = 4,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned SW      = $clog2(NSRC + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [AW-1:0]        ID_RS,
  input  logic [AW-1:0]        ID_RT,
  input  logic [AW-1:0]        EX_RS,
  input  logic [AW-1:0]        EX_RT,
  input  logic                 ID_UseRS,
  input  logic                 ID_UseRT,
  input  logic                 ID_Branch,
  input  logic                 EX_RegWrite,
  input  logic                 EX_MemRead,
  input  logic [AW-1:0]        EX_RegDest,
  input  logic [NSRC-1:0]      SrcRegWrite,
  input  logic [NSRC*AW-1:0]   SrcRegDest,
  input  logic [NSRC-1:0]      SrcLoadPending,
  input  logic                 EX_MulStart,
  input  logic                 Flush,
  output logic [SW-1:0]        EXFwdA,
  output logic [SW-1:0]        EXFwdB,
  output logic [SW-1:0]        IDFwdA,
  output logic [SW-1:0]        IDFwdB,
  output logic                 StallID,
  output logic                 StallEX,
  output logic                 MulBusy,
  output logic [15:0]          StallCount
);

  localparam logic [3:0] CNT_START = 4'(MUL_LAT - 1);

  typedef enum logic {IDLE, MUL_WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Operand is a real register (register 0 is hardwired when ZERO_REG is set).
  function automatic logic live(input logic [AW-1:0] op);
    return !((ZERO_REG != 0) && (op == '0));
  endfunction

  // Youngest writing source wins, so scan from oldest to youngest and let later hits override.
  function automatic logic [SW-1:0] fwd_sel(input logic [AW-1:0] op,
                                            input logic [NSRC-1:0] wr,
                                            input logic [NSRC*AW-1:0] dest);
    logic [SW-1:0] s;
    s = '0;
    for (int k = int'(NSRC) - 1; k >= 0; k--) begin
      if (wr[k] && (dest[k*AW +: AW] == op)) s = SW'(k + 1);
    end
    if (!live(op)) s = '0;
    return s;
  endfunction

  function automatic logic sel_pending(input logic [SW-1:0] sel,
                                       input logic [NSRC-1:0] pend);
    logic p;
    p = 1'b0;
    for (int k = 0; k < int'(NSRC); k++) begin
      if (sel == SW'(k + 1)) p = pend[k];
    end
    return p;
  endfunction

  logic use_a, use_b, ex_hit, load_use, branch_alu, branch_load;

  always_comb begin
    EXFwdA = fwd_sel(EX_RS, SrcRegWrite, SrcRegDest);
    EXFwdB = fwd_sel(EX_RT, SrcRegWrite, SrcRegDest);
    IDFwdA = fwd_sel(ID_RS, SrcRegWrite, SrcRegDest);
    IDFwdB = fwd_sel(ID_RT, SrcRegWrite, SrcRegDest);

    use_a       = ID_UseRS && live(ID_RS);
    use_b       = ID_UseRT && live(ID_RT);
    ex_hit      = (use_a && (EX_RegDest == ID_RS)) || (use_b && (EX_RegDest == ID_RT));
    load_use    = EX_MemRead && EX_RegWrite && ex_hit;
    branch_alu  = ID_Branch && EX_RegWrite && ex_hit;
    branch_load = ID_Branch && ((ID_UseRS && sel_pending(IDFwdA, SrcLoadPending)) ||
                                (ID_UseRT && sel_pending(IDFwdB, SrcLoadPending)));

    StallID = (load_use || branch_alu || branch_load || StallEX) && !Flush;
  end

  // Multi-cycle operation sequencing; flush aborts and takes priority over a new start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (EX_MulStart) begin
            state_d = MUL_WAIT;
            cnt_d   = CNT_START;
          end
        end
        MUL_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallEX = (state_q == MUL_WAIT);
  assign MulBusy = (state_q == MUL_WAIT);

  // Saturating stall statistic, deliberately untouched by flush.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      StallCount <= 16'd0;
    end else if (StallID && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule
